// File: rtl/fine_sync_ctrl.sv
// Sequencer for the fine-timing correlator: resets it, loads the preamble reference,
// then streams one gap-free burst per coarse detection and reports the peak index.
module fine_sync_ctrl #(
   parameter int unsigned W       = 13,
   parameter int unsigned PRE_LEN = 63,
   parameter int unsigned MAX_RUN = 140,
   parameter int unsigned RST_CYC = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         coarse_det,
   input  logic         in_valid,
   input  logic [W-1:0] in_real,
   input  logic [W-1:0] in_imag,
   output logic         pre_rd,
   output logic [5:0]   pre_addr,
   input  logic [W-1:0] pre_real,
   input  logic [W-1:0] pre_imag,
   output logic         corr_rst,
   output logic         corr_preamble_valid,
   output logic         corr_input_valid,
   output logic [W-1:0] corr_real,
   output logic [W-1:0] corr_imag,
   input  logic [7:0]   corr_fine_num,
   input  logic         corr_fine_done,
   output logic         sync_valid,
   output logic [7:0]   sync_offset,
   output logic         sync_err,
   output logic         busy
);

   localparam int unsigned AW = 6;
   localparam int unsigned CW = $clog2(MAX_RUN + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CRST, S_LOAD, S_ARMED, S_RUN, S_DONE
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            pre_rd_q;
   logic [AW-1:0]   pre_addr_q;
   logic            rd_d1_q;
   logic            corr_rst_q;
   logic            pv_q;
   logic            civ_q;
   logic [W-1:0]    corr_real_q;
   logic [W-1:0]    corr_imag_q;
   logic            sync_valid_q;
   logic [7:0]      sync_offset_q;
   logic            sync_err_q;
   logic            busy_q;

   // Sequencer; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         pre_rd_q      <= 1'b0;
         pre_addr_q    <= '0;
         rd_d1_q       <= 1'b0;
         corr_rst_q    <= 1'b1;
         pv_q          <= 1'b0;
         civ_q         <= 1'b0;
         corr_real_q   <= '0;
         corr_imag_q   <= '0;
         sync_valid_q  <= 1'b0;
         sync_offset_q <= '0;
         sync_err_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         sync_valid_q <= 1'b0;
         sync_err_q   <= 1'b0;
         if (!enable) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pre_rd_q    <= 1'b0;
            pre_addr_q  <= '0;
            rd_d1_q     <= 1'b0;
            corr_rst_q  <= 1'b0;
            pv_q        <= 1'b0;
            civ_q       <= 1'b0;
            corr_real_q <= '0;
            corr_imag_q <= '0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q    <= S_CRST;
                  cnt_q      <= '0;
                  corr_rst_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
               S_CRST: begin
                  if (cnt_q == CW'(RST_CYC - 1)) begin
                     state_q    <= S_LOAD;
                     cnt_q      <= '0;
                     corr_rst_q <= 1'b0;
                     pre_rd_q   <= 1'b1;
                     pre_addr_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_LOAD: begin
                  // ROM data lands one cycle after the read and is re-registered onto the bus.
                  rd_d1_q     <= pre_rd_q;
                  pv_q        <= rd_d1_q;
                  corr_real_q <= rd_d1_q ? pre_real : '0;
                  corr_imag_q <= rd_d1_q ? pre_imag : '0;
                  if (pre_rd_q) begin
                     if (pre_addr_q == AW'(PRE_LEN - 1)) begin
                        pre_rd_q   <= 1'b0;
                        pre_addr_q <= '0;
                     end else begin
                        pre_addr_q <= pre_addr_q + 1'b1;
                     end
                  end
                  if (!pre_rd_q && !rd_d1_q && pv_q) begin
                     state_q <= S_ARMED;
                     busy_q  <= 1'b0;
                  end
               end
               S_ARMED: begin
                  if (coarse_det) begin
                     state_q <= S_RUN;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (corr_fine_done) begin
                     state_q       <= S_DONE;
                     civ_q         <= 1'b0;
                     corr_real_q   <= '0;
                     corr_imag_q   <= '0;
                     sync_valid_q  <= 1'b1;
                     sync_offset_q <= corr_fine_num;
                  end else if (!in_valid || cnt_q == CW'(MAX_RUN - 1)) begin
                     // A gap would silently clear the correlator, so it is treated like a timeout.
                     state_q     <= S_CRST;
                     cnt_q       <= '0;
                     corr_rst_q  <= 1'b1;
                     civ_q       <= 1'b0;
                     corr_real_q <= '0;
                     corr_imag_q <= '0;
                     sync_err_q  <= 1'b1;
                  end else begin
                     civ_q       <= 1'b1;
                     corr_real_q <= in_real;
                     corr_imag_q <= in_imag;
                     cnt_q       <= cnt_q + 1'b1;
                  end
               end
               S_DONE: begin
                  state_q <= S_ARMED;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pre_rd              = pre_rd_q;
   assign pre_addr            = pre_addr_q;
   assign corr_rst            = corr_rst_q;
   assign corr_preamble_valid = pv_q;
   assign corr_input_valid    = civ_q;
   assign corr_real           = corr_real_q;
   assign corr_imag           = corr_imag_q;
   assign sync_valid          = sync_valid_q;
   assign sync_offset         = sync_offset_q;
   assign sync_err            = sync_err_q;
   assign busy                = busy_q;

endmodule
